// File: rtl/request_button_conditioner.sv
// Per-button synchroniser, debouncer, press edge detector and request latch for the traffic FSM.
// Optional auto-expiry of unacknowledged requests is built only when REQUEST_TIMEOUT_EN is defined.
module request_button_conditioner #(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                   clk,
  input  logic                   not_reset,
  input  logic [NUM_BUTTONS-1:0] not_button,
  input  logic [NUM_BUTTONS-1:0] service_ack,
  output logic [NUM_BUTTONS-1:0] button_level,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] request_pending,
  output logic [NUM_BUTTONS-1:0] request_expired
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << 20)) begin : g_bad_param
    $error("request_button_conditioner: parameter out of legal range");
  end

  logic [NUM_BUTTONS-1:0] sync1, sync2, stable;
  logic [NUM_BUTTONS-1:0] accept, rise, expire, pending_next;
  logic [CW-1:0]          db_cnt [NUM_BUTTONS];

  // Buttons are active-low on the board; invert once at the first flop.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~not_button;
      sync2 <= sync1;
    end
  end

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
    end
    rise = accept & sync2;
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      stable <= '0;
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign button_level = stable;

`ifdef REQUEST_TIMEOUT_EN
  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_cnt [NUM_BUTTONS];

  // Ack and a fresh press both outrank expiry in the same cycle.
  always_comb begin
    expire = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      expire[i] = request_pending[i] && !service_ack[i] && !rise[i] &&
                  (wait_cnt[i] == TO_LAST);
    end
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      request_expired <= '0;
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) wait_cnt[i] <= '0;
    end else begin
      request_expired <= expire;
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        if (rise[i] || service_ack[i] || !request_pending[i] || expire[i])
          wait_cnt[i] <= '0;
        else
          wait_cnt[i] <= wait_cnt[i] + TW'(1);
      end
    end
  end
`else
  assign expire          = '0;
  assign request_expired = '0;
`endif

  // A press in the same cycle as an ack leaves the request standing.
  assign pending_next = rise | (request_pending & ~service_ack & ~expire);

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      press_pulse     <= '0;
      request_pending <= '0;
    end else begin
      press_pulse     <= rise;
      request_pending <= pending_next;
    end
  end

endmodule

// File: tb/tb_request_button_conditioner.sv
// Directed bench for request_button_conditioner with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8.
module tb_request_button_conditioner;

  logic       clk = 1'b0;
  logic       not_reset;
  logic [3:0] not_button;
  logic [3:0] service_ack;
  logic [3:0] button_level, press_pulse, request_pending, request_expired;

  int vectors     = 0;
  int miscompares = 0;

  request_button_conditioner #(
    .NUM_BUTTONS    (4),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .not_reset      (not_reset),
    .not_button     (not_button),
    .service_ack    (service_ack),
    .button_level   (button_level),
    .press_pulse    (press_pulse),
    .request_pending(request_pending),
    .request_expired(request_expired)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    not_reset   = 1'b0;
    not_button  = '1;
    service_ack = '0;
    tick(2);
    not_reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    not_reset   = 1'b0;
    not_button  = '1;
    service_ack = '0;
    #1;
    obs = {button_level, press_pulse, request_pending, request_expired};
    vectors++;
    if (obs !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0000", obs);
    end
    tick(3);
    not_reset = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick(1);
      obs = {button_level, press_pulse, request_pending, request_expired};
      vectors++;
      if (obs !== 16'h0) begin
        miscompares++;
        $display("FAIL idle cycle %0d: got %h want 0000", c, obs);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] el, ep, en;
    do_reset();
    not_button[1] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      el = (e >= 6) ? 4'b0010 : 4'b0000;
      ep = (e == 6) ? 4'b0010 : 4'b0000;
      en = (e >= 6) ? 4'b0010 : 4'b0000;
      vectors++;
      if ({button_level, press_pulse, request_pending} !== {el, ep, en}) begin
        miscompares++;
        $display("FAIL clean_press edge %0d: got lvl=%b pls=%b pend=%b want lvl=%b pls=%b pend=%b",
                 e, button_level, press_pulse, request_pending, el, ep, en);
      end
    end
    // Release: level falls after debounce, no pulse, request still held.
    not_button[1] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      el = (e >= 6) ? 4'b0000 : 4'b0010;
      vectors++;
      if ({button_level, press_pulse, request_pending} !== {el, 4'b0000, 4'b0010}) begin
        miscompares++;
        $display("FAIL release edge %0d: got lvl=%b pls=%b pend=%b want lvl=%b pls=0000 pend=0010",
                 e, button_level, press_pulse, request_pending, el);
      end
    end
  endtask

  task automatic test_bounce();
    logic [8:0] pattern;
    logic [11:0] obs;
    logic [3:0] el, ep;
    do_reset();
    pattern = 9'b111001000;  // raw bit0 per edge, LSB first: low 3, high, low 2, high
    for (int e = 0; e < 16; e++) begin
      not_button[0] = (e < 9) ? pattern[e] : 1'b1;
      tick(1);
      obs = {button_level, press_pulse, request_pending};
      vectors++;
      if (obs !== 12'h0) begin
        miscompares++;
        $display("FAIL bounce edge %0d: got %h want 000", e + 1, obs);
      end
    end
    // Low for exactly DEBOUNCE_CYCLES edges is accepted.
    not_button[0] = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      tick(1);
      if (e == 4) not_button[0] = 1'b1;
      el = (e >= 6 && e <= 9) ? 4'b0001 : 4'b0000;
      ep = (e == 6) ? 4'b0001 : 4'b0000;
      vectors++;
      if ({button_level, press_pulse} !== {el, ep}) begin
        miscompares++;
        $display("FAIL min_press edge %0d: got lvl=%b pls=%b want lvl=%b pls=%b",
                 e, button_level, press_pulse, el, ep);
      end
    end
  endtask

  task automatic test_ack();
    do_reset();
    not_button[2] = 1'b0;
    tick(6);
    vectors++;
    if (request_pending !== 4'b0100 || press_pulse !== 4'b0100) begin
      miscompares++;
      $display("FAIL ack_setup: got pend=%b pls=%b want pend=0100 pls=0100", request_pending, press_pulse);
    end
    tick(2);
    service_ack[2] = 1'b1;
    tick(1);
    service_ack[2] = 1'b0;
    vectors++;
    if (request_pending !== 4'b0000) begin
      miscompares++;
      $display("FAIL ack_clear: got pend=%b want 0000", request_pending);
    end
    tick(3);
    vectors++;
    if (request_pending !== 4'b0000 || button_level !== 4'b0100) begin
      miscompares++;
      $display("FAIL ack_held: got pend=%b lvl=%b want pend=0000 lvl=0100", request_pending, button_level);
    end
    // Release, then press again with the ack landing on the press edge.
    not_button[2] = 1'b1;
    tick(8);
    not_button[2] = 1'b0;
    tick(5);
    service_ack[2] = 1'b1;
    tick(1);
    service_ack[2] = 1'b0;
    vectors++;
    if (request_pending !== 4'b0100 || press_pulse !== 4'b0100) begin
      miscompares++;
      $display("FAIL ack_vs_press: got pend=%b pls=%b want pend=0100 pls=0100", request_pending, press_pulse);
    end
    service_ack[0] = 1'b1;
    tick(1);
    service_ack[0] = 1'b0;
    vectors++;
    if (request_pending !== 4'b0100 || press_pulse !== 4'b0000) begin
      miscompares++;
      $display("FAIL ack_other_bit: got pend=%b pls=%b want pend=0100 pls=0000", request_pending, press_pulse);
    end
  endtask

  task automatic test_held_reset();
    int pulses;
    logic [3:0] e3;
    do_reset();
    not_button[3] = 1'b0;
    tick(7);
    vectors++;
    if (request_pending !== 4'b1000) begin
      miscompares++;
      $display("FAIL held_setup: got pend=%b want 1000", request_pending);
    end
    not_reset = 1'b0;
    #1;
    vectors++;
    if ({button_level, press_pulse, request_pending, request_expired} !== 16'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want 0000",
               {button_level, press_pulse, request_pending, request_expired});
    end
    tick(3);
    not_reset = 1'b1;
    pulses = 0;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      if (press_pulse[3]) pulses++;
      e3 = (e >= 6) ? 4'b1000 : 4'b0000;
      vectors++;
      if ({button_level, press_pulse, request_pending} !== {e3, (e == 6) ? 4'b1000 : 4'b0000, e3}) begin
        miscompares++;
        $display("FAIL held_reset edge %0d: got lvl=%b pls=%b pend=%b", e, button_level, press_pulse, request_pending);
      end
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL held_reset_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_parallel();
    do_reset();
    not_button = 4'b1010;
    tick(6);
    vectors++;
    if ({button_level, press_pulse, request_pending} !== {4'b0101, 4'b0101, 4'b0101}) begin
      miscompares++;
      $display("FAIL parallel_press: got lvl=%b pls=%b pend=%b want 0101 each",
               button_level, press_pulse, request_pending);
    end
    service_ack = 4'b0001;
    tick(1);
    service_ack = '0;
    vectors++;
    if (request_pending !== 4'b0100) begin
      miscompares++;
      $display("FAIL parallel_ack: got pend=%b want 0100", request_pending);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    not_button[0] = 1'b0;
    tick(6);
    vectors++;
    if (request_pending !== 4'b0001) begin
      miscompares++;
      $display("FAIL timeout_setup: got pend=%b want 0001", request_pending);
    end
`ifdef REQUEST_TIMEOUT_EN
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      vectors++;
      if (request_pending !== ((k < 8) ? 4'b0001 : 4'b0000) ||
          request_expired !== ((k == 8) ? 4'b0001 : 4'b0000)) begin
        miscompares++;
        $display("FAIL timeout k=%0d: got pend=%b exp=%b", k, request_pending, request_expired);
      end
    end
`else
    for (int k = 1; k <= 120; k++) begin
      tick(1);
      vectors++;
      if (request_pending !== 4'b0001 || request_expired !== 4'b0000) begin
        miscompares++;
        $display("FAIL no_timeout k=%0d: got pend=%b exp=%b want pend=0001 exp=0000",
                 k, request_pending, request_expired);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_ack();
    test_held_reset();
    test_parallel();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/request_button_conditioner.md
Name: request_button_conditioner

Overview:
Input-side counterpart to the traffic controller's request consumer. Takes the raw active-low KEY push buttons and conditions each one through a synchroniser, a debouncer and a rising-edge detector. It then holds each button's request latched until the controller FSM acknowledges service. It sits between the board KEY pins and the FSM request inputs: reset, southbound-left, NS-walk and EW-walk/EVM.

Parameters:
NUM_BUTTONS, 4, number of independent button channels; index 0..NUM_BUTTONS-1.
DEBOUNCE_CYCLES, 16, consecutive clk cycles a changed synchronised level must persist before it is accepted; legal range 1..65535.
TIMEOUT_CYCLES, 1024, cycles a pending request may wait before it auto-expires; used only with the optional feature; legal range 1..2^20.

Ports:
clk  input  1  system clock (divided clock from the clock block)
not_reset  input  1  asynchronous active-low reset
not_button  input  NUM_BUTTONS  raw KEY inputs, active-low, asynchronous to clk
service_ack  input  NUM_BUTTONS  one-cycle-or-longer pulse from the FSM; bit i clears request_pending[i]
button_level  output  NUM_BUTTONS  debounced active-high button state
press_pulse  output  NUM_BUTTONS  one-cycle pulse per accepted press
request_pending  output  NUM_BUTTONS  latched request, held until acknowledged
request_expired  output  NUM_BUTTONS  one-cycle pulse when a pending request times out; constant 0 without the optional feature

Behaviour:
- Clocking and reset: one clock domain, clk. not_reset is asynchronous, active-low.
- Reset values: all outputs 0, all synchroniser flops 0 (released), all counters 0.
- Synchroniser, per bit: two flops, sync1 <= ~not_button, then sync2 <= sync1. This is the only inversion point.
- Debounce, per bit: stable level S (drives button_level) and counter C, width ceil(log2(DEBOUNCE_CYCLES+1)).
  - sync2 == S: C <= 0.
  - sync2 != S and C == DEBOUNCE_CYCLES-1: S <= sync2, C <= 0.
  - Otherwise: C <= C+1.
- Latency: a clean raw edge sampled at edge 1 changes button_level at edge 2+DEBOUNCE_CYCLES.
- Glitch rejection: any excursion shorter than DEBOUNCE_CYCLES synchronised cycles restarts C and never reaches S.
- Edge detect: at the edge where S goes 0->1, press_pulse[i] <= 1; the next edge returns it to 0. Release (S going 1->0) produces no pulse.
- Pending latch, per bit:
  - Set at the same edge press_pulse is set.
  - Cleared at any edge where service_ack[i]=1 and no set occurs.
  - Simultaneous set and ack: set wins, request_pending stays 1.
  - Ack while not pending: no effect.
  - A further press while already pending: pulse still issued, pending stays 1; no counting or queueing.
- Channels are fully independent; simultaneous activity on several bits is handled in parallel.
- Button held through reset release: the channel behaves as a fresh press. button_level, press_pulse and request_pending assert at edge 2+DEBOUNCE_CYCLES after the first edge following reset deassertion.
- Reset asserted mid-debounce or mid-pending: everything clears immediately (asynchronous). No pulse is emitted on reset.

Optional Feature:
Macro REQUEST_TIMEOUT_EN.
- Defined: each channel has a wait counter.
  - It counts while request_pending[i]=1 and clears when pending is 0, on ack, or on a new press.
  - On the edge where it would reach TIMEOUT_CYCLES, request_pending[i] <= 0 and request_expired[i] <= 1 for one cycle.
  - Ack and expiry in the same cycle: ack takes priority, no expired pulse.
  - Press and expiry in the same cycle: press takes priority, pending stays 1, counter restarts.
- Not defined: no wait counters are built, request_expired is tied to 0, and pending clears only on ack or reset.

Test Plan:
- Reset and idle: DEBOUNCE_CYCLES=4, not_reset pulsed low, all not_button=1 -> every output 0 for 100 cycles.
- Clean press: not_button[1] 1->0 before edge 1 -> button_level[1]=1, press_pulse[1]=1 and request_pending[1]=1 at edge 6; press_pulse[1]=0 at edge 7; other bits stay 0.
- Bounce rejection: bit 0 held low for 3 cycles, then high, low 2, high -> no change on any output.
- Ack handshake: pending[2]=1, then service_ack[2]=1 for one cycle -> pending[2]=0 next edge. Second test: ack coincides with a new press_pulse[2] -> pending[2] stays 1.
- Held through reset: not_button[3]=0 while not_reset goes low then high -> press_pulse[3] once, 6 cycles after the first post-reset edge.
- REQUEST_TIMEOUT_EN with TIMEOUT_CYCLES=8: press bit 0 and never ack -> pending[0] drops and request_expired[0] pulses for 1 cycle exactly 8 cycles after pending set. Without the macro, pending[0] stays 1 for 100+ cycles and request_expired=0.
